// File: rtl/tank_pio_in.sv
// Avalon-MM input PIO slave: synchronizer, per-bit debouncer, sticky edge capture, maskable level irq.
// Build option: define TANK_PIO_IN_DEBOUNCE_EN to generate the debounce counters; otherwise deb = sync.
module tank_pio_in #(
  parameter int               WIDTH           = 2,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] sync, deb, deb_dly_q, deb_dly_d;
  logic [WIDTH-1:0] rise, fall, ev;
  logic [WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d, clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d, wr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int j = 1; j < SYNC_STAGES; j++) sync_d[j] = sync_q[j-1];
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef TANK_PIO_IN_DEBOUNCE_EN
  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_bit_q, deb_bit_d;

    // Counter only runs while sync disagrees; the >= compare keeps it from ever wrapping.
    always_comb begin
      cnt_d     = '0;
      deb_bit_d = deb_bit_q;
      if (sync[i] != deb_bit_q) begin
        if (cnt_q >= CNT_MAX) deb_bit_d = sync[i];
        else                  cnt_d     = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q     <= '0;
        deb_bit_q <= RESET_VALUE[i];
      end else begin
        cnt_q     <= cnt_d;
        deb_bit_q <= deb_bit_d;
      end
    end

    assign deb[i] = deb_bit_q;
  end
`else
  assign deb = sync;
`endif

  assign deb_dly_d = deb;
  assign rise      = deb & ~deb_dly_q;
  assign fall      = ~deb & deb_dly_q;

  always_comb begin
    case (EDGE_TYPE)
      1:       ev = fall;
      2:       ev = rise | fall;
      default: ev = rise;
    endcase
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irqmask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    // OR-ing ev after the clear lets a same-cycle event win over the write.
    edgecap_d = (edgecap_q & ~clr) | ev;
    irq_d     = |(edgecap_q & irqmask_q);
    case (address)
      2'd0:    readdata_d = 32'(deb);
      2'd2:    readdata_d = 32'(irqmask_q);
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= {SYNC_STAGES{RESET_VALUE}};
      deb_dly_q  <= RESET_VALUE;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      deb_dly_q  <= deb_dly_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_tank_pio_in.sv
// Bench for tank_pio_in: three instances (rising/2b, any/32b, falling/2b) checked against a history-based model.
module tb_tank_pio_in;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [1:0]  in_a, in_c;
  logic [31:0] in_b;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;
  logic        chk_en = 1'b0;
  int          errs = 0, checks = 0;

`ifdef TANK_PIO_IN_DEBOUNCE_EN
  localparam int LAT_A = 2 + 8;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT_A = 2;
  localparam bit DEB_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  tank_pio_in #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0), .RESET_VALUE(2'b00)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));
  tank_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(2), .RESET_VALUE(32'h0)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));
  tank_pio_in #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(1), .RESET_VALUE(2'b00)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));

  // Reference model: input history per instance; deb flips once the last D synced samples all disagree.
  logic [31:0] m_ph [3][16];
  logic [31:0] m_deb [3], m_debd [3], m_ec [3], m_msk [3], m_rd [3];
  logic        m_irq [3];

  function automatic int wof(int k); return (k == 1) ? 32 : 2; endfunction
  function automatic int eof(int k); return (k == 0) ? 0 : ((k == 1) ? 2 : 1); endfunction
  function automatic int dof(int k); return (k == 1) ? 1 : 8; endfunction

  task automatic model_step();
    logic [31:0] wm, dcur, ev, inv, ndeb;
    bit wr, flip;
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        for (int j = 0; j < 16; j++) m_ph[k][j] = '0;
        m_deb[k] = '0; m_debd[k] = '0; m_ec[k] = '0; m_msk[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
        continue;
      end
      wm   = (wof(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wof(k)) - 32'd1);
      wr   = chipselect && !write_n;
      inv  = (k == 0) ? {30'd0, in_a} : ((k == 1) ? in_b : {30'd0, in_c});
      dcur = DEB_ON ? m_deb[k] : m_ph[k][1];
      case (eof(k))
        0:       ev = dcur & ~m_debd[k];
        1:       ev = ~dcur & m_debd[k];
        default: ev = dcur ^ m_debd[k];
      endcase
      case (address)
        2'd0:    m_rd[k] = dcur;
        2'd2:    m_rd[k] = m_msk[k];
        2'd3:    m_rd[k] = m_ec[k];
        default: m_rd[k] = '0;
      endcase
      m_irq[k] = |(m_ec[k] & m_msk[k]);
      m_ec[k]  = (((wr && address == 2'd3) ? (m_ec[k] & ~writedata) : m_ec[k]) | ev) & wm;
      if (wr && address == 2'd2) m_msk[k] = writedata & wm;
      m_debd[k] = dcur;
      ndeb = m_deb[k];
      for (int b = 0; b < wof(k); b++) begin
        flip = 1'b1;
        for (int m = 0; m < dof(k); m++) if (m_ph[k][1+m][b] == m_deb[k][b]) flip = 1'b0;
        if (flip) ndeb[b] = ~m_deb[k][b];
      end
      m_deb[k] = ndeb;
      for (int j = 15; j > 0; j--) m_ph[k][j] = m_ph[k][j-1];
      m_ph[k][0] = inv & wm;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_rd_a", rd_a, m_rd[0]);  chk("cyc_irq_a", {31'd0, irq_a}, {31'd0, m_irq[0]});
      chk("cyc_rd_b", rd_b, m_rd[1]);  chk("cyc_irq_b", {31'd0, irq_b}, {31'd0, m_irq[1]});
      chk("cyc_rd_c", rd_c, m_rd[2]);  chk("cyc_irq_c", {31'd0, irq_c}, {31'd0, m_irq[2]});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] in_v;
    bit          wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0] = '{32'hA5A5_5A5A, 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'hA5A5_5A5A};
    vecs[1] = '{32'hA5A5_5A5A, 1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'h0000_0000};
    vecs[2] = '{32'h0000_0000, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 2'd0, 32'h0,         2'd0, 32'hFFFF_FFFF};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 2'd2, 32'hDEAD_BEEF, 2'd2, 32'hDEAD_BEEF};

    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in_a = 2'b11; in_b = '0; in_c = 2'b00;
    tick(3);
    chk("rst_rd_a", rd_a, 32'h0); chk("rst_irq_a", {31'd0, irq_a}, 32'h0);
    chk("rst_rd_b", rd_b, 32'h0); chk("rst_irq_b", {31'd0, irq_b}, 32'h0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // reset then idle: inputs held high appear after the full latency
    tick(LAT_A + 2);
    chk("t1_data", rd_a, 32'h3);
    in_a = 2'b00;
    tick(LAT_A + 3);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    tick(1);
    chk("t1_ec_clear", rd_a, 32'h0);

`ifdef TANK_PIO_IN_DEBOUNCE_EN
    in_a = 2'b01; tick(5); in_a = 2'b00;
    tick(LAT_A + 4);
    address = 2'd0; tick(1); chk("t2_glitch_data", rd_a, 32'h0);
    address = 2'd3; tick(1); chk("t2_glitch_ec", rd_a, 32'h0);
`endif
    in_a = 2'b01;
    tick(LAT_A + 3);
    address = 2'd0; tick(1); chk("t2_hold_data", rd_a, 32'h1);
    address = 2'd3; tick(1); chk("t2_hold_ec", rd_a, 32'h1);

    // interrupt path
    in_a = 2'b00; tick(LAT_A + 3);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'h2);
    in_a = 2'b01; address = 2'd3; tick(LAT_A + 3);
    chk("t3_ec_b0", rd_a, 32'h1); chk("t3_irq_b0", {31'd0, irq_a}, 32'h0);
    in_a = 2'b11; tick(LAT_A + 3);
    chk("t3_ec_b1", rd_a, 32'h3); chk("t3_irq_b1", {31'd0, irq_a}, 32'h1);
    bus_wr(2'd3, 32'h2);
    tick(1);
    chk("t3_ec_clr", rd_a, 32'h1); chk("t3_irq_clr", {31'd0, irq_a}, 32'h0);

    // set wins over a same-cycle clear
    in_a = 2'b01; tick(LAT_A + 3);
    in_a = 2'b11; tick(LAT_A + 3);
    chk("t4_pre_irq", {31'd0, irq_a}, 32'h1);
    in_a = 2'b01; tick(LAT_A + 3);
    in_a = 2'b11; tick(LAT_A);
    bus_wr(2'd3, 32'h2);
    chk("t4_irq0", {31'd0, irq_a}, 32'h1);
    tick(1);
    chk("t4_irq1", {31'd0, irq_a}, 32'h1); chk("t4_ec", rd_a, 32'h3);
    tick(1);
    chk("t4_irq2", {31'd0, irq_a}, 32'h1);

    // mask bits above WIDTH are dropped
    bus_wr(2'd2, 32'hFFFF_FFFF);
    address = 2'd2; tick(1);
    chk("mask_a", rd_a, 32'h3); chk("mask_c", rd_c, 32'h3); chk("mask_b", rd_b, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd3, 32'hFFFF_FFFF);

    // edge type: falling-only on c, any-edge on b
    in_c = 2'b01; address = 2'd3; tick(LAT_A + 3);
    chk("t5_fall_rise", rd_c, 32'h0);
    in_c = 2'b00; tick(LAT_A + 3);
    chk("t5_fall_fall", rd_c, 32'h1);
    in_b = 32'h1; tick(6);
    chk("t5_any_rise", rd_b, 32'h1);
    bus_wr(2'd3, 32'h1); tick(1);
    chk("t5_any_clr", rd_b, 32'h0);
    in_b = 32'h0; tick(6);
    chk("t5_any_fall", rd_b, 32'h1);
    bus_wr(2'd3, 32'hFFFF_FFFF);

    // 32-bit instance register table
    for (int i = 0; i < 5; i++) begin
      in_b = vecs[i].in_v;
      if (vecs[i].wr) bus_wr(vecs[i].waddr, vecs[i].wdata);
      tick(6);
      address = vecs[i].raddr;
      tick(1);
      chk($sformatf("t6_vec%0d", i), rd_b, vecs[i].exp);
    end
    bus_wr(2'd2, 32'h0);

    // random traffic, checked every cycle by the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) in_a = 2'($urandom);
      if ($urandom_range(0, 9) == 0) in_c = 2'($urandom);
      if ($urandom_range(0, 3) == 0) in_b = $urandom;
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = 1'($urandom);
      address    = 2'($urandom);
      writedata  = $urandom;
      tick(1);
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
